note_prefetch_unit: RTL and testbench
=====================================

Name: note_prefetch_unit

Overview:
- Upstream fetch stage for the note player.
- Reads 16-bit instruction words sequentially from the external SRAM (read-only) and buffers them in a small FIFO.
- Presents the words to the player over a valid/ready handshake, so the player never waits on SRAM timing.
- Stops fetching after it captures an END instruction (bits [15:12] == 4'b0000) or the last SRAM address.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- READ_WAIT, 2: idle cycles between driving SRAM_A and sampling SRAM_D; range 0..7.
- BASE_ADDR, 18'h00000: address of the first instruction fetched after START.

Ports:
- CLK  in  1  system clock (50 MHz).
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; begin fetching at BASE_ADDR.
- SRAM_A  out  18  SRAM address, registered.
- SRAM_D  in  16  SRAM read data.
- SRAM_WE  out  1  tied 1 (never write).
- SRAM_CE  out  1  tied 0.
- SRAM_OE  out  1  tied 0.
- SRAM_LB  out  1  tied 0.
- SRAM_UB  out  1  tied 0.
- INS_DATA  out  16  FIFO head word (show-ahead).
- INS_VALID  out  1  FIFO non-empty.
- INS_READY  in  1  consumer accepts INS_DATA this cycle.
- HALTED  out  1  fetching finished (END captured or address limit reached).
- LEVEL  out  5  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (RST=1 at an edge): applies in any state, including mid-read.
  - State goes to IDLE; pc = BASE_ADDR; SRAM_A = 0.
  - FIFO is emptied; LEVEL = 0, INS_VALID = 0, HALTED = 0.
  - INS_DATA = 0; any in-flight read is discarded.
- States: IDLE, WAIT, STALL, HALT.
- IDLE: START=1 at edge k -> SRAM_A <= pc, wait counter <= READ_WAIT, state WAIT.
- WAIT:
  - SRAM_A is held stable.
  - Counter decrements each edge while nonzero.
  - At the edge where the counter is 0, which is edge k+READ_WAIT+1:
    - SRAM_D is sampled and pushed into the FIFO.
    - pc <= pc+1.
    - INS_VALID is high from that edge onward.
- After a capture (same edge):
  - If the captured word has [15:12]==4'b0000, or pc was 18'h3FFFF -> state HALT, HALTED <= 1, no further address is issued. pc does not wrap.
  - Else if the post-edge occupancy (including this push and any same-edge pop) < DEPTH -> SRAM_A <= pc+1, re-enter WAIT with the counter reloaded.
  - Else -> state STALL.
- Steady-state throughput: one word per READ_WAIT+1 cycles.
- STALL: on the first edge where the post-edge occupancy < DEPTH (i.e. a pop occurs) -> SRAM_A <= pc, enter WAIT.
- HALT:
  - The FIFO continues to drain; HALTED stays 1.
  - START=1 restarts: FIFO flushed, pc = BASE_ADDR, HALTED <= 0, same timing as IDLE.
- START is ignored in WAIT and STALL.
- FIFO:
  - Circular buffer with a head pointer, a tail pointer and an occupancy counter of log2(DEPTH)+1 bits.
  - Pop when INS_VALID && INS_READY; INS_DATA advances to the next entry on that edge.
  - Simultaneous push and pop: LEVEL unchanged, data order preserved. With LEVEL==0 the pushed word becomes the head; no bypass, so INS_VALID rises one edge later.
  - The FIFO never overflows: a fetch is issued only if a slot is guaranteed free, because at most one read is ever in flight.
  - INS_READY while INS_VALID=0 has no effect.
  - INS_DATA is stable while INS_VALID=1 and INS_READY=0.
- Word content is not interpreted beyond the END check. Note and BPM words pass through unmodified.

Test Plan:
- Basic fetch: SRAM model words 0x8123, 0x1060, 0x8234, 0x0000 at 0..3; READ_WAIT=2; INS_READY=1; START at edge 0 -> INS_VALID rises after edge 3; words delivered in order at edges 3, 6, 9, 12; HALTED=1 after edge 12; SRAM_A never exceeds 3.
- Backpressure: 10 non-END words, INS_READY=0 -> LEVEL reaches 4, state STALL, SRAM_A holds 4. Pulse INS_READY for one cycle -> head 0 popped; the address-4 fetch is issued on that edge; LEVEL returns to 4 READ_WAIT+1 edges later.
- Simultaneous push/pop: LEVEL=2, INS_READY=1 on the capture edge -> LEVEL stays 2; the popped word is the old head; the new word is queued at the tail.
- Restart from HALT: after END is delivered, pulse START -> FIFO flushed, first word re-fetched from BASE_ADDR, HALTED falls on the START edge.
- Reset mid-read: assert RST during WAIT with LEVEL=3 -> next cycle LEVEL=0, INS_VALID=0, SRAM_A=0, state IDLE; no stale push occurs after RST deasserts.
- Address limit: BASE_ADDR=18'h3FFFE, no END in memory -> exactly 2 words pushed; HALTED=1; no fetch of address 0.

Source files
------------

// File: rtl/note_prefetch_if.sv
// note_prefetch_if
// Bundles the prefetch unit's external signals: the read-only SRAM bus,
// the instruction valid/ready handshake toward the player, and the
// START / HALTED / LEVEL control and status lines.
//   master : the prefetch unit (drives SRAM address/strobes and INS_*)
//   slave  : the SRAM model plus the consumer (drives SRAM_D, INS_READY, START)
interface note_prefetch_if;
    logic        START;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_D;
    logic        SRAM_WE;
    logic        SRAM_CE;
    logic        SRAM_OE;
    logic        SRAM_LB;
    logic        SRAM_UB;
    logic [15:0] INS_DATA;
    logic        INS_VALID;
    logic        INS_READY;
    logic        HALTED;
    logic [4:0]  LEVEL;

    modport master (
        input  START, SRAM_D, INS_READY,
        output SRAM_A, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB,
        output INS_DATA, INS_VALID, HALTED, LEVEL
    );

    modport slave (
        output START, SRAM_D, INS_READY,
        input  SRAM_A, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB,
        input  INS_DATA, INS_VALID, HALTED, LEVEL
    );
endinterface

// File: rtl/note_prefetch_unit.sv
// note_prefetch_unit
// Fetches 16-bit instruction words sequentially from a read-only SRAM and
// buffers them in a DEPTH-entry FIFO presented show-ahead to the player.
// Fetching stops after an END word ([15:12] == 0) or address 18'h3FFFF.
// Ports:
//   CLK  : system clock
//   RST  : synchronous active-high reset
//   bus  : note_prefetch_if.master (START, SRAM_*, INS_*, HALTED, LEVEL)
//
// state    | meaning
// ST_IDLE  | after reset, waiting for START
// ST_WAIT  | address driven, counting down READ_WAIT before sampling SRAM_D
// ST_STALL | FIFO full, waiting for a pop before issuing the next read
// ST_HALT  | END or last address captured; FIFO drains, START restarts
module note_prefetch_unit #(
    parameter int          DEPTH     = 4,
    parameter int          READ_WAIT = 2,
    parameter logic [17:0] BASE_ADDR = 18'h00000
) (
    input  logic             CLK,
    input  logic             RST,
    note_prefetch_if.master  bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [2:0]  WAIT_LOAD = 3'(READ_WAIT);
    localparam logic [17:0] LAST_ADDR = 18'h3FFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL, ST_HALT} state_t;

    state_t        state;
    logic [17:0]   pc;
    logic [17:0]   sram_a;
    logic [2:0]    wcnt;
    logic          halted;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [AW:0]   level_next;
    logic          push;
    logic          pop;
    logic          at_end;

    assign pop    = (count != '0) && bus.INS_READY;
    assign push   = (state == ST_WAIT) && (wcnt == '0);
    assign at_end = (bus.SRAM_D[15:12] == 4'b0000) || (pc == LAST_ADDR);

    // Occupancy after this edge; drives the fetch/stall decision so a read
    // is only issued when its slot is guaranteed.
    always_comb begin
        level_next = count;
        if (push && !pop)
            level_next = count + LVL_ONE;
        else if (!push && pop)
            level_next = count - LVL_ONE;
    end

    // Storage is not reset; entries are only visible while counted.
    always_ff @(posedge CLK) begin
        if (push)
            mem[tail] <= bus.SRAM_D;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            pc     <= BASE_ADDR;
            sram_a <= '0;
            wcnt   <= '0;
            halted <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            if (pop)
                head <= head + PTR_ONE;
            if (push)
                tail <= tail + PTR_ONE;
            count <= level_next;

            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        sram_a <= pc;
                        wcnt   <= WAIT_LOAD;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 3'd1;
                    end else if (at_end) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        // The next address goes out even when stalling; the
                        // SRAM is read-only and nothing samples it until WAIT.
                        pc     <= pc + 18'd1;
                        sram_a <= pc + 18'd1;
                        if (level_next < FULL)
                            wcnt <= WAIT_LOAD;
                        else
                            state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (level_next < FULL) begin
                        sram_a <= pc;
                        wcnt   <= WAIT_LOAD;
                        state  <= ST_WAIT;
                    end
                end
                ST_HALT: begin
                    if (bus.START) begin
                        head   <= '0;
                        tail   <= '0;
                        count  <= '0;
                        pc     <= BASE_ADDR;
                        sram_a <= BASE_ADDR;
                        halted <= 1'b0;
                        wcnt   <= WAIT_LOAD;
                        state  <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SRAM_A    = sram_a;
    assign bus.SRAM_WE   = 1'b1;
    assign bus.SRAM_CE   = 1'b0;
    assign bus.SRAM_OE   = 1'b0;
    assign bus.SRAM_LB   = 1'b0;
    assign bus.SRAM_UB   = 1'b0;
    assign bus.INS_VALID = (count != '0);
    assign bus.INS_DATA  = (count != '0) ? mem[head] : '0;
    assign bus.HALTED    = halted;
    assign bus.LEVEL     = 5'(count);
endmodule

// File: tb/tb_note_prefetch_unit.sv
// tb_note_prefetch_unit
// Directed bench: a per-edge vector table for the basic fetch, then
// hand-written sequences for restart, backpressure, push/pop overlap,
// reset mid-read and the address limit (second instance at 18'h3FFFE).
module tb_note_prefetch_unit;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #10 CLK = ~CLK;

    note_prefetch_if b0 ();
    note_prefetch_if bl ();

    logic [15:0] sram [16];
    assign b0.SRAM_D = sram[b0.SRAM_A[3:0]];
    assign bl.SRAM_D = 16'h8000 | bl.SRAM_A[15:0];

    note_prefetch_unit #(.DEPTH(4), .READ_WAIT(2), .BASE_ADDR(18'h00000)) u_dut (
        .CLK(CLK), .RST(RST), .bus(b0.master)
    );
    note_prefetch_unit #(.DEPTH(4), .READ_WAIT(2), .BASE_ADDR(18'h3FFFE)) u_lim (
        .CLK(CLK), .RST(RST), .bus(bl.master)
    );

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [4:0]  exp_level;
        logic        exp_halted;
        logic [17:0] exp_a;
    } vec_t;
    vec_t vecs [15];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [15:0] d,
                             input logic [4:0] l, input logic h, input logic [17:0] a);
        chk({tag, " valid"},  32'(b0.INS_VALID), 32'(v));
        chk({tag, " level"},  32'(b0.LEVEL),     32'(l));
        chk({tag, " halted"}, 32'(b0.HALTED),    32'(h));
        chk({tag, " sram_a"}, 32'(b0.SRAM_A),    32'(a));
        if (v) chk({tag, " data"}, 32'(b0.INS_DATA), 32'(d));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        b0.START = 1'b0; b0.INS_READY = 1'b0;
        bl.START = 1'b0; bl.INS_READY = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        int zero_seen;
        for (int i = 0; i < 16; i++) sram[i] = 16'h0000;
        do_reset();

        // reset state and tied strobes
        chk_state("reset", 1'b0, 16'h0, 5'd0, 1'b0, 18'h0);
        chk("reset data", 32'(b0.INS_DATA), 32'h0);
        chk("lim reset sram_a", 32'(bl.SRAM_A), 32'h0);
        chk("strobes", 32'({b0.SRAM_WE, b0.SRAM_CE, b0.SRAM_OE, b0.SRAM_LB, b0.SRAM_UB}), 32'b10000);

        // basic fetch, READY held high; entry i is the state after edge i
        sram[0] = 16'h8123; sram[1] = 16'h1060; sram[2] = 16'h8234; sram[3] = 16'h0000;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h8123, 5'd1, 1'b0, 18'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h1060, 5'd1, 1'b0, 18'd2};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h8234, 5'd1, 1'b0, 18'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 18'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, 5'd1, 1'b1, 18'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 18'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 18'd3};
        for (int i = 0; i < 15; i++) begin
            b0.START = vecs[i].start;
            b0.INS_READY = vecs[i].ready;
            step();
            chk_state($sformatf("basic e%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_level, vecs[i].exp_halted, vecs[i].exp_a);
        end
        b0.INS_READY = 1'b0;

        // restart from HALT with a full FIFO: START flushes and refetches
        do_reset();
        b0.START = 1'b1; step(); b0.START = 1'b0;      // edge 0
        repeat (14) step();                           // edges 1..14
        chk_state("restart full", 1'b1, 16'h8123, 5'd4, 1'b1, 18'd3);
        b0.START = 1'b1; step(); b0.START = 1'b0;      // edge 15
        chk_state("restart flush", 1'b0, 16'h0, 5'd0, 1'b0, 18'd0);
        step(); step();                                // edges 16,17
        chk_state("restart e17", 1'b0, 16'h0, 5'd0, 1'b0, 18'd0);
        step();                                        // edge 18
        chk_state("restart e18", 1'b1, 16'h8123, 5'd1, 1'b0, 18'd1);

        // backpressure and simultaneous push/pop
        do_reset();
        for (int i = 0; i < 16; i++) sram[i] = 16'h9000 + 16'(i);
        b0.START = 1'b1; step(); b0.START = 1'b0;      // edge 0
        repeat (12) step();                           // edges 1..12
        chk_state("bp full", 1'b1, 16'h9000, 5'd4, 1'b0, 18'd4);
        step(); step();                                // edges 13,14
        chk_state("bp stall", 1'b1, 16'h9000, 5'd4, 1'b0, 18'd4);
        b0.INS_READY = 1'b1; step(); b0.INS_READY = 1'b0;  // edge 15
        chk_state("bp pop", 1'b1, 16'h9001, 5'd3, 1'b0, 18'd4);
        step(); step();                                // edges 16,17
        chk_state("bp e17", 1'b1, 16'h9001, 5'd3, 1'b0, 18'd4);
        step();                                        // edge 18
        chk_state("bp refill", 1'b1, 16'h9001, 5'd4, 1'b0, 18'd5);
        b0.INS_READY = 1'b1; step(); step();           // edges 19,20
        chk_state("pp lvl2", 1'b1, 16'h9003, 5'd2, 1'b0, 18'd5);
        b0.INS_READY = 1'b0; step();                   // edge 21
        b0.INS_READY = 1'b1; step();                   // edge 22: capture + pop
        chk_state("pp same edge", 1'b1, 16'h9004, 5'd2, 1'b0, 18'd6);
        step();                                        // edge 23
        chk_state("pp tail", 1'b1, 16'h9005, 5'd1, 1'b0, 18'd6);
        b0.INS_READY = 1'b0;

        // reset mid-read with three words buffered
        do_reset();
        b0.START = 1'b1; step(); b0.START = 1'b0;      // edge 0
        repeat (10) step();                           // edges 1..10
        chk_state("mid pre", 1'b1, 16'h9000, 5'd3, 1'b0, 18'd3);
        RST = 1'b1; step(); RST = 1'b0;                // edge 11
        chk_state("mid rst", 1'b0, 16'h0, 5'd0, 1'b0, 18'd0);
        chk("mid rst data", 32'(b0.INS_DATA), 32'h0);
        b0.INS_READY = 1'b1;
        repeat (6) step();
        chk_state("mid after", 1'b0, 16'h0, 5'd0, 1'b0, 18'd0);
        b0.INS_READY = 1'b0;

        // address limit: start at 18'h3FFFE, no END in memory
        zero_seen = 0;
        bl.START = 1'b1; step(); bl.START = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bl.SRAM_A == 18'h0) zero_seen++;
        end
        chk("lim level", 32'(bl.LEVEL), 32'd2);
        chk("lim halted", 32'(bl.HALTED), 32'd1);
        chk("lim sram_a", 32'(bl.SRAM_A), 32'h3FFFF);
        chk("lim head", 32'(bl.INS_DATA), 32'hFFFE);
        chk("lim no wrap", 32'(zero_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
